// File: rtl/arc4_ctrl.sv
// ARC4 top-level sequencer: runs S-box init, KSA and PRGA in order and muxes the S memory port.
// Optional per-phase watchdog enabled by defining ARC4_CTRL_WATCHDOG_EN.
module arc4_ctrl #(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic        done,
    output logic        err,
    output logic [1:0]  phase,
    input  logic [23:0] key,
    output logic [23:0] key_q,
    output logic        init_en,
    output logic        ksa_en,
    output logic        prga_en,
    input  logic        init_rdy,
    input  logic        ksa_rdy,
    input  logic        prga_rdy,
    input  logic [7:0]  init_s_addr,
    input  logic [7:0]  ksa_s_addr,
    input  logic [7:0]  prga_s_addr,
    input  logic [7:0]  init_s_wrdata,
    input  logic [7:0]  ksa_s_wrdata,
    input  logic [7:0]  prga_s_wrdata,
    input  logic        init_s_wren,
    input  logic        ksa_s_wren,
    input  logic        prga_s_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT_GO  = 4'd1,
        S_INIT_ACK = 4'd2,
        S_INIT_RUN = 4'd3,
        S_KSA_GO   = 4'd4,
        S_KSA_ACK  = 4'd5,
        S_KSA_RUN  = 4'd6,
        S_PRGA_GO  = 4'd7,
        S_PRGA_ACK = 4'd8,
        S_PRGA_RUN = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] key_d;
    logic        done_q, done_d;

    // Main state, latched key and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= 24'h000000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

`ifdef ARC4_CTRL_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_q, wdog_d;
    logic        err_q, err_d;

    function automatic logic is_wait_state(input state_t s);
        case (s)
            S_INIT_ACK, S_INIT_RUN,
            S_KSA_ACK,  S_KSA_RUN,
            S_PRGA_ACK, S_PRGA_RUN: is_wait_state = 1'b1;
            default:                is_wait_state = 1'b0;
        endcase
    endfunction

    function automatic logic is_go_state(input state_t s);
        case (s)
            S_INIT_GO, S_KSA_GO, S_PRGA_GO: is_go_state = 1'b1;
            default:                        is_go_state = 1'b0;
        endcase
    endfunction

    // Watchdog counter and sticky abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state logic: one GO cycle, wait for rdy low (ACK), wait for rdy high (RUN).
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_INIT_GO;
                    key_d   = key;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT_GO:  state_d = S_INIT_ACK;
            S_INIT_ACK: state_d = init_rdy ? S_INIT_ACK : S_INIT_RUN;
            S_INIT_RUN: state_d = init_rdy ? S_KSA_GO   : S_INIT_RUN;
            S_KSA_GO:   state_d = S_KSA_ACK;
            S_KSA_ACK:  state_d = ksa_rdy  ? S_KSA_ACK  : S_KSA_RUN;
            S_KSA_RUN:  state_d = ksa_rdy  ? S_PRGA_GO  : S_KSA_RUN;
            S_PRGA_GO:  state_d = S_PRGA_ACK;
            S_PRGA_ACK: state_d = prga_rdy ? S_PRGA_ACK : S_PRGA_RUN;
            S_PRGA_RUN: begin
                if (prga_rdy) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_PRGA_RUN;
                end
            end
            default:    state_d = S_IDLE;
        endcase

`ifdef ARC4_CTRL_WATCHDOG_EN
        err_d  = err_q;
        wdog_d = wdog_q;
        if (state_q == S_IDLE && en) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        // A wait state that is not leaving and has exhausted its budget aborts the run.
        if (is_wait_state(state_q) && (state_d == state_q) && (wdog_q == WDOG_LIMIT)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
            wdog_d  = 16'h0000;
        end else if (is_go_state(state_d)) begin
            wdog_d = 16'h0000;
        end else if (is_wait_state(state_q)) begin
            wdog_d = wdog_q + 16'h0001;
        end else begin
            wdog_d = wdog_q;
        end
`endif
    end

    assign rdy     = (state_q == S_IDLE);
    assign done    = done_q;
    assign init_en = (state_q == S_INIT_GO);
    assign ksa_en  = (state_q == S_KSA_GO);
    assign prga_en = (state_q == S_PRGA_GO);

    // Phase code and S-port grant, decoded from the state register only.
    always_comb begin
        phase    = 2'd0;
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
        case (state_q)
            S_INIT_GO, S_INIT_ACK, S_INIT_RUN: begin
                phase    = 2'd1;
                s_addr   = init_s_addr;
                s_wrdata = init_s_wrdata;
                s_wren   = init_s_wren;
            end
            S_KSA_GO, S_KSA_ACK, S_KSA_RUN: begin
                phase    = 2'd2;
                s_addr   = ksa_s_addr;
                s_wrdata = ksa_s_wrdata;
                s_wren   = ksa_s_wren;
            end
            S_PRGA_GO, S_PRGA_ACK, S_PRGA_RUN: begin
                phase    = 2'd3;
                s_addr   = prga_s_addr;
                s_wrdata = prga_s_wrdata;
                s_wren   = prga_s_wren;
            end
            default: begin
                phase    = 2'd0;
                s_addr   = 8'h00;
                s_wrdata = 8'h00;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_ctrl.sv
// Directed bench for arc4_ctrl: cycle vector table, modelled full run, async reset and watchdog sequences.
module tb_arc4_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] key;
    logic        rdy, done, err;
    logic [1:0]  phase;
    logic [23:0] key_q;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;

    logic        use_model;
    logic        stuck_ksa;
    logic [2:0]  t_rdy;
    logic [2:0]  t_wren;
    logic [2:0]  m_rdy;
    int          m_cnt [3];
    int          len0, len1, len2;
    logic [2:0]  en_v;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arc4_ctrl #(.WDOG_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done), .err(err),
        .phase(phase), .key(key), .key_q(key_q),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_s_addr(8'h11), .ksa_s_addr(8'h12), .prga_s_addr(8'h13),
        .init_s_wrdata(8'hA1), .ksa_s_wrdata(8'hA2), .prga_s_wrdata(8'hA3),
        .init_s_wren(t_wren[0]), .ksa_s_wren(t_wren[1]), .prga_s_wren(t_wren[2]),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    assign en_v     = {prga_en, ksa_en, init_en};
    assign init_rdy = use_model ? m_rdy[0] : t_rdy[0];
    assign ksa_rdy  = use_model ? (m_rdy[1] | stuck_ksa) : t_rdy[1];
    assign prga_rdy = use_model ? m_rdy[2] : t_rdy[2];

    // Engine models: rdy drops the edge after en and stays low for the configured busy time.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdy <= 3'b111;
            for (int i = 0; i < 3; i++) m_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (en_v[i]) begin
                    m_rdy[i] <= 1'b0;
                    m_cnt[i] <= (i == 0) ? len0 : ((i == 1) ? len1 : len2);
                end else if (!m_rdy[i]) begin
                    if (m_cnt[i] <= 1) m_rdy[i] <= 1'b1;
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end
        end
    end

    // Run monitor.
    logic mon_on = 1'b0;
    int   en_log [$];
    int   ph_log [$];
    int   done_cnt, key_bad, init_cnt;
    logic [1:0]  last_ph;
    logic [23:0] mon_key;
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 3; i++) if (en_v[i]) en_log.push_back(i);
            if (init_en) init_cnt = init_cnt + 1;
            if (phase != last_ph) begin
                ph_log.push_back(int'(phase));
                last_ph = phase;
            end
            if (done) done_cnt = done_cnt + 1;
            if (!rdy && key_q !== mon_key) key_bad = key_bad + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon_start(input logic [23:0] k);
        en_log.delete();
        ph_log.delete();
        done_cnt = 0;
        key_bad  = 0;
        init_cnt = 0;
        last_ph  = 2'd0;
        mon_key  = k;
        mon_on   = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic [23:0] key;
        logic [2:0]  rdy;
        logic [2:0]  wren;
        logic        e_rdy;
        logic        e_done;
        logic [1:0]  e_phase;
        logic [2:0]  e_ens;
        logic [23:0] e_key;
        logic [7:0]  e_addr;
        logic [7:0]  e_wd;
        logic        e_wren;
    } vec_t;

    vec_t tv [14];
    bit   seen;

    initial begin
        // inputs applied before an edge; expectations are outputs after that edge
        tv[0]  = '{1'b1, 24'h000018, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, 3'b001, 24'h000018, 8'h11, 8'hA1, 1'b0};
        tv[1]  = '{1'b0, 24'h000000, 3'b110, 3'b001, 1'b0, 1'b0, 2'd1, 3'b000, 24'h000018, 8'h11, 8'hA1, 1'b1};
        tv[2]  = '{1'b0, 24'h000000, 3'b110, 3'b010, 1'b0, 1'b0, 2'd1, 3'b000, 24'h000018, 8'h11, 8'hA1, 1'b0};
        tv[3]  = '{1'b0, 24'h000000, 3'b110, 3'b011, 1'b0, 1'b0, 2'd1, 3'b000, 24'h000018, 8'h11, 8'hA1, 1'b1};
        tv[4]  = '{1'b0, 24'h000000, 3'b111, 3'b010, 1'b0, 1'b0, 2'd2, 3'b010, 24'h000018, 8'h12, 8'hA2, 1'b1};
        tv[5]  = '{1'b0, 24'h000000, 3'b101, 3'b000, 1'b0, 1'b0, 2'd2, 3'b000, 24'h000018, 8'h12, 8'hA2, 1'b0};
        tv[6]  = '{1'b1, 24'hFFFFFF, 3'b101, 3'b010, 1'b0, 1'b0, 2'd2, 3'b000, 24'h000018, 8'h12, 8'hA2, 1'b1};
        tv[7]  = '{1'b1, 24'hFFFFFF, 3'b111, 3'b000, 1'b0, 1'b0, 2'd3, 3'b100, 24'h000018, 8'h13, 8'hA3, 1'b0};
        tv[8]  = '{1'b0, 24'h000000, 3'b011, 3'b100, 1'b0, 1'b0, 2'd3, 3'b000, 24'h000018, 8'h13, 8'hA3, 1'b1};
        tv[9]  = '{1'b0, 24'h000000, 3'b011, 3'b100, 1'b0, 1'b0, 2'd3, 3'b000, 24'h000018, 8'h13, 8'hA3, 1'b1};
        tv[10] = '{1'b0, 24'h000000, 3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 3'b000, 24'h000018, 8'h00, 8'h00, 1'b0};
        tv[11] = '{1'b1, 24'hABCDEF, 3'b111, 3'b111, 1'b0, 1'b0, 2'd1, 3'b001, 24'hABCDEF, 8'h11, 8'hA1, 1'b1};
        tv[12] = '{1'b0, 24'h000000, 3'b110, 3'b000, 1'b0, 1'b0, 2'd1, 3'b000, 24'hABCDEF, 8'h11, 8'hA1, 1'b0};
        tv[13] = '{1'b0, 24'h000000, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, 3'b000, 24'hABCDEF, 8'h11, 8'hA1, 1'b0};

        rst = 1'b1; en = 1'b0; key = 24'h000000;
        use_model = 1'b0; stuck_ksa = 1'b0;
        t_rdy = 3'b111; t_wren = 3'b000;
`ifdef ARC4_CTRL_WATCHDOG_EN
        len0 = 4; len1 = 8; len2 = 6;
`else
        len0 = 256; len1 = 768; len2 = 20;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_phase", 32'(phase), 32'd0);
        chk("reset_key_q", 32'(key_q), 32'd0);
        chk("reset_done_err", 32'({done, err}), 32'd0);

        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            en = tv[v].en; key = tv[v].key; t_rdy = tv[v].rdy; t_wren = tv[v].wren;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rdy", v), 32'(rdy), 32'(tv[v].e_rdy));
            chk($sformatf("v%0d_done", v), 32'(done), 32'(tv[v].e_done));
            chk($sformatf("v%0d_phase", v), 32'(phase), 32'(tv[v].e_phase));
            chk($sformatf("v%0d_ens", v), 32'(en_v), 32'(tv[v].e_ens));
            chk($sformatf("v%0d_key_q", v), 32'(key_q), 32'(tv[v].e_key));
            chk($sformatf("v%0d_s_addr", v), 32'(s_addr), 32'(tv[v].e_addr));
            chk($sformatf("v%0d_s_wrdata", v), 32'(s_wrdata), 32'(tv[v].e_wd));
            chk($sformatf("v%0d_s_wren", v), 32'(s_wren), 32'(tv[v].e_wren));
        end

        // Full run against engine models.
        @(negedge clk);
        en = 1'b0; t_wren = 3'b000;
        do_reset();
        use_model = 1'b1;
        mon_start(24'h000018);
        key = 24'h000018; en = 1'b1;
        @(negedge clk);
        en = 1'b0; key = 24'h000000;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        repeat (4) @(negedge clk);
        mon_on = 1'b0;
        chk("run_done_seen", 32'(seen), 32'd1);
        chk("run_done_count", 32'(done_cnt), 32'd1);
        chk("run_en_count", 32'(en_log.size()), 32'd3);
        if (en_log.size() == 3) begin
            chk("run_en_order", 32'((en_log[0] * 16) + (en_log[1] * 4) + en_log[2]), 32'h06);
        end
        chk("run_phase_count", 32'(ph_log.size()), 32'd4);
        if (ph_log.size() == 4) begin
            chk("run_phase_order",
                32'((ph_log[0] * 64) + (ph_log[1] * 16) + (ph_log[2] * 4) + ph_log[3]), 32'h6C);
        end
        chk("run_key_stable", 32'(key_bad), 32'd0);
        chk("run_end_rdy", 32'(rdy), 32'd1);

        // Asynchronous reset in the middle of PRGA_RUN.
        t_wren = 3'b100;
        key = 24'h5A5A5A; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (phase == 2'd3) seen = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("pre_rst_phase", 32'(phase), 32'd3);
        chk("pre_rst_s_wren", 32'(s_wren), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rdy", 32'(rdy), 32'd1);
        chk("async_rst_phase", 32'(phase), 32'd0);
        chk("async_rst_s_wren", 32'(s_wren), 32'd0);
        chk("async_rst_key_q", 32'(key_q), 32'd0);
        @(negedge clk);
        chk("rst_next_prga_en", 32'(prga_en), 32'd0);
        chk("rst_next_outputs", 32'({rdy, done, err, phase, s_addr, s_wrdata, s_wren}), 32'h200000);
        rst = 1'b0;
        t_wren = 3'b000;

`ifdef ARC4_CTRL_WATCHDOG_EN
        // KSA never acknowledges: watchdog must abort with err and no done.
        @(negedge clk);
        stuck_ksa = 1'b1;
        mon_start(24'h000077);
        key = 24'h000077; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (err) seen = 1'b1;
        end
        mon_on = 1'b0;
        chk("wdog_err_seen", 32'(seen), 32'd1);
        chk("wdog_idle", 32'({rdy, phase}), 32'h4);
        chk("wdog_no_done", 32'(done_cnt), 32'd0);
        stuck_ksa = 1'b0;
        repeat (3) @(negedge clk);
        chk("wdog_err_sticky", 32'(err), 32'd1);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("wdog_err_cleared", 32'(err), 32'd0);
        chk("wdog_restart_phase", 32'(phase), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arc4_ctrl.md
# arc4_ctrl

Top-level sequencer for the ARC4 decryption datapath. On one start request it runs the three engines in fixed order: S-box init, then KSA, then PRGA. Each engine is driven through its en/rdy handshake. The block owns the single-port S memory and multiplexes it to whichever engine is in its phase. The ct/pt ports are not touched here; they connect directly to the PRGA.

## Interface
Parameters:
- WDOG_CYCLES, 4096: per-phase cycle limit; used only when ARC4_CTRL_WATCHDOG_EN is defined.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; accepted only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- done  out  1  one-cycle pulse when PRGA completes.
- err  out  1  watchdog abort flag; sticky until the next accepted en.
- phase  out  2  0=idle, 1=init, 2=ksa, 3=prga.
- key  in  24  key; latched on the accepted en.
- key_q  out  24  latched key, driven to the KSA and PRGA.
- init_en / ksa_en / prga_en  out  1 each  engine start pulses.
- init_rdy / ksa_rdy / prga_rdy  in  1 each  engine ready signals.
- init_s_addr, ksa_s_addr, prga_s_addr  in  8 each  engine S address.
- init_s_wrdata, ksa_s_wrdata, prga_s_wrdata  in  8 each  engine S write data.
- init_s_wren, ksa_s_wren, prga_s_wren  in  1 each  engine S write enable.
- s_addr  out  8  to S memory.
- s_wrdata  out  8  to S memory.
- s_wren  out  1  to S memory.

s_rddata fans out to all engines outside this block.

## Operation
- States: IDLE, then {INIT,KSA,PRGA}_GO → _ACK → _RUN, then back to IDLE.
- IDLE: rdy=1 and phase=0.
  - en=1 at a posedge moves to INIT_GO, latches key_q=key, and clears err.
  - Any en while not in IDLE is ignored, with no queuing.
- X_GO (one cycle): X_en=1, then unconditionally to X_ACK. X_en is high only in X_GO.
- X_ACK: waits for X_rdy=0, which shows the engine accepted; then to X_RUN.
- X_RUN: waits for X_rdy=1, which shows the engine finished.
  - INIT_RUN goes to KSA_GO.
  - KSA_RUN goes to PRGA_GO.
  - PRGA_RUN goes to IDLE and sets done for exactly one cycle.
- If X_rdy is already 0 when X_GO is entered, X_en is still pulsed; the ACK/RUN sequence is unchanged.
- S-port grant, combinational from the state register with zero added latency:
  - In the INIT_* states, s_* = init_s_*.
  - In the KSA_* states, s_* = ksa_s_*.
  - In the PRGA_* states, s_* = prga_s_*.
  - In IDLE: s_addr=0, s_wrdata=0, s_wren=0.
  - A non-granted engine's s_wren never reaches memory.
- phase is combinational from the state.
- Reset, asynchronous and possible mid-operation, forces IDLE at once with rdy=1, done=0, err=0, phase=0, key_q=0, all *_en=0, s_addr=0, s_wrdata=0, s_wren=0.
  - Engines are reset by the same rst; no abort handshake.

## Timing
- en accepted at edge N: INIT_GO during N+1 (init_en=1), INIT_ACK from N+2.
- Each phase costs 2 cycles plus the engine's busy time, with a minimum of 3 cycles per phase when rdy drops one cycle after en.
- done rises the cycle after prga_rdy=1 is sampled in PRGA_RUN; rdy=1 in that same cycle.
- A new en may be accepted in the same cycle done is high.
- No combinational path from en to any *_en; *_en are decoded from registered state only.

## Configuration
- ARC4_CTRL_WATCHDOG_EN defined:
  - A 16-bit counter clears on entry to each X_GO and increments in X_ACK and X_RUN.
  - When the count reaches WDOG_CYCLES-1 without the awaited rdy edge, the block goes to IDLE, sets err=1, and gives no done pulse.
  - err clears on the next accepted en.
- Undefined: no counter, err tied 0, and ACK/RUN wait indefinitely.

## Test plan
- Reset then idle: rst=1 mid-PRGA_RUN → next cycle rdy=1, phase=0, s_wren=0, prga_en=0, key_q=0.
- Full run: key=24'h000018, engines model 256/768/N-cycle busy times → init_en, ksa_en and prga_en each pulse once in order; phase goes 1,2,3,0; exactly one done pulse; key_q=24'h000018 throughout.
- S mux isolation: ksa_s_wren=1 held during INIT_RUN → s_wren follows init_s_wren only; in KSA_RUN, s_addr=ksa_s_addr every cycle.
- Busy en ignored: en=1 with key=24'hFFFFFF during KSA_RUN → key_q unchanged; no extra init_en; one done.
- Back-to-back: en=1 in the done cycle → INIT_GO the next cycle with the new key latched.
- Watchdog (macro defined, WDOG_CYCLES=16): hold ksa_rdy=1 forever → 16 cycles after KSA_GO, state IDLE, err=1, done never pulses; the next en clears err.
